// File: rtl/shift_cmd_if.sv
// Handshake and shifter-drive bundle between the datapath control, the command
// sequencer and the combinational left barrel shifter.
interface shift_cmd_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          in_valid;
   logic          in_ready;
   logic [15:0]   in_data;
   logic [3:0]    in_amt;
   logic [15:0]   sh_i;
   logic          sh_s0;
   logic          sh_s1;
   logic          sh_s2;
   logic          sh_s3;
   logic [15:0]   sh_o;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   out_data;
   logic [CW-1:0] count;

   modport slave (
      input  in_valid, in_data, in_amt, sh_o, out_ready,
      output in_ready, sh_i, sh_s0, sh_s1, sh_s2, sh_s3, out_valid, out_data, count
   );

   modport master (
      output in_valid, in_data, in_amt, sh_o, out_ready,
      input  in_ready, sh_i, sh_s0, sh_s1, sh_s2, sh_s3, out_valid, out_data, count
   );
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Command FIFO feeding a combinational left barrel shifter, with a registered
// result stage presented downstream over valid/ready.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | result register empty, out_valid low
// ST_HOLD | result register holds an undelivered result, out_valid high
module shift_cmd_sequencer #(
   parameter int DEPTH = 4
) (
   input logic         clk,
   input logic         rst,
   shift_cmd_if.slave  bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic {
      ST_IDLE,
      ST_HOLD
   } out_state_t;

   out_state_t    state_q;
   out_state_t    state_d;

   logic [15:0]   data_mem [DEPTH];
   logic [3:0]    amt_mem  [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic [15:0]   out_data_q;

   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [15:0]   head_data;
   logic [3:0]    head_amt;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

   // in_ready depends only on occupancy, so a pop cannot open a slot in the same cycle
   assign push = bus.in_valid & ~full;
   assign pop  = ~empty & ((state_q == ST_IDLE) | bus.out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         data_mem[wr_ptr] <= bus.in_data;
         amt_mem[wr_ptr]  <= bus.in_amt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q <= '0;
      end else if (pop) begin
         out_data_q <= bus.sh_o;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (pop) begin
               state_d = ST_HOLD;
            end else if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign head_data = data_mem[rd_ptr];
   assign head_amt  = amt_mem[rd_ptr];

   assign bus.sh_i      = empty ? 16'h0000 : head_data;
   assign bus.sh_s0     = ~empty & head_amt[0];
   assign bus.sh_s1     = ~empty & head_amt[1];
   assign bus.sh_s2     = ~empty & head_amt[2];
   assign bus.sh_s3     = ~empty & head_amt[3];

   assign bus.in_ready  = ~full;
   assign bus.out_valid = (state_q == ST_HOLD);
   assign bus.out_data  = out_data_q;
   assign bus.count     = count_q;
endmodule

// File: doc/shift_cmd_sequencer.md
# shift_cmd_sequencer

Command buffer and result register that feeds the 16-bit combinational left barrel shifter (`barrel_shifter_left16`) and collects its output. It sits between the datapath control logic and the shifter. Upstream issues (data, shift-amount) commands over a valid/ready handshake; commands are queued in a FIFO. The head command drives the shifter's `i`/`s0..s3` inputs, and the shifted result is registered and presented downstream over a second valid/ready handshake.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; a power of 2, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  command can be accepted.
- `in_data`  in  16  operand to shift.
- `in_amt`  in  4  left-shift amount, 0..15.
- `sh_i`  out  16  to shifter input `i`.
- `sh_s0`, `sh_s1`, `sh_s2`, `sh_s3`  out  1 each  to shifter selects: shift by 1, 2, 4 and 8 respectively.
- `sh_o`  in  16  from shifter output `o`.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  16  registered shift result.
- `count`  out  $clog2(DEPTH+1)  FIFO occupancy, not counting the result register.

## Operation
- **Push.** `in_valid & in_ready` writes {`in_data`, `in_amt`} at the write pointer, advances the pointer (mod DEPTH) and increments `count`.
- **Ready.** `in_ready = (count != DEPTH)`. It is a function of registered state only, with no combinational path from `out_ready`.
- **Head drive.**
  - When `count != 0`: `sh_i` = head data, `{sh_s3, sh_s2, sh_s1, sh_s0}` = head amount.
  - When `count == 0`: all shifter-drive outputs are 0.
  - These outputs are combinational from FIFO state only.
- **Pop/capture.** Condition: `count != 0 & (!out_valid | out_ready)`. When it holds, the edge:
  - loads `out_data <= sh_o`,
  - sets `out_valid <= 1`,
  - advances the read pointer and decrements `count`.
- **Drain without refill.** `out_valid & out_ready` with no pop clears `out_valid`. `out_data` holds its last value.
- **Simultaneous push and pop.** `count` is unchanged. Both pointers advance.
- **Required arithmetic.** `out_data == (data << amt) & 16'hFFFF`. Bits shifted past bit 15 are discarded. Zeros fill from the LSB.
- **Total capacity.** DEPTH + 1 commands in flight (FIFO plus result register).
- **Ordering.** Results are delivered strictly in command order. No drops, no duplicates.
- **Handshake rules.** While `out_valid & !out_ready`, `out_data` and `out_valid` are held stable. Upstream may hold `in_valid` indefinitely; acceptance occurs only on a cycle where `in_ready` is high.

## Timing
- **Reset.** `rst` high at an edge clears:
  - both pointers, `count = 0`, `out_valid = 0`, `out_data = 0`;
  - therefore `in_ready = 1` and all `sh_*` outputs 0 from the following cycle.
  - Reset mid-operation discards all queued and registered commands.
  - A push presented in the reset cycle is ignored.
- **Latency.** A command accepted at edge N into an empty FIFO with `out_valid = 0` drives the shifter during cycle N..N+1. It is captured at edge N+1, so `out_valid` is high after edge N+1 (2 edges from push).
- **Throughput.** 1 command per cycle sustained while `out_ready = 1`.
- **Full.** With `count == DEPTH`, `in_ready = 0` that cycle, even if a pop occurs in the same cycle. The freed slot is visible next cycle.
- **Empty with out_ready.** `count == 0` and `out_ready = 1`: `out_valid` drops after the edge.
- **Wrap-around.** Pointers wrap DEPTH-1 to 0 with no bubble.

## Test plan
- **Single command.** Push `0x00F1`, amt 4, `out_ready = 1`. Expect `out_data = 0x0F10`, `out_valid` high exactly 2 edges after the push, then low.
- **Amount sweep.**
  - `0x1234` amt 0 gives `0x1234`.
  - `0x0001` amt 15 gives `0x8000`.
  - `0x1234` amt 8 gives `0x3400`.
  - `0xFFFF` amt 9 gives `0xFE00`.
  - `0xABCD` amt 13 gives `0xA000`.
  - Check `sh_s3..s0` equals the amount during the head cycle.
- **Backpressure.** Hold `out_ready = 0` and push 6 commands back-to-back.
  - 5 are accepted; `in_ready` is 0 from the cycle after the 5th.
  - `count = 4`; `out_data` holds the 1st result stable.
  - Release `out_ready`: the 5 results arrive in order, one per cycle.
- **Streaming with wrap.** Push 20 random commands with `in_valid` and `out_ready` always 1. Expect 20 correct in-order results, one per cycle after 2-cycle fill; `count` never exceeds 1.
- **Simultaneous push/pop at full.** With `count = 4` and `out_valid = 1`, pulse `out_ready`. Expect `count = 3` next cycle, `in_ready` rising the cycle after the pop and not during it, and no lost command.
- **Reset mid-stream.** Assert `rst` with 3 queued commands and `out_valid = 1`. After the edge, expect `count = 0`, `out_valid = 0`, `out_data = 0`, `sh_i = 0`, `in_ready = 1`. The next command then completes normally.
